// File: rtl/pipeline_sched_pkg.sv
// Shared types and helpers for the pipeline round-robin scheduler family.
//   state_t   : scheduler state (WARMUP, RUN, DRAIN)
//   id_width  : bits needed to hold a requester index, never less than 1
package pipeline_sched_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_rr_scheduler_if.sv
// Requester-side bus of the pipeline round-robin scheduler.
//   req        : per-requester request
//   req_data   : per-requester data item
//   gnt        : onehot0 grant, item accepted this cycle
//   resp_valid : onehot0 response strobe, result for requester i on pipeline output
// master = requester logic, slave = scheduler.
interface pipeline_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            resp_valid;

  modport master (
    output req,
    output req_data,
    input  gnt,
    input  resp_valid
  );

  modport slave (
    input  req,
    input  req_data,
    output gnt,
    output resp_valid
  );

endinterface

// File: rtl/pipeline_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : onehot0 grant to the first requester at or above ptr (with wrap)
module rr_arbiter
  import pipeline_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  int               idx;
  logic [PTR_W-1:0] idx_w;
  logic             found;

  // Walk the requesters starting at ptr; the first active one wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        gnt[idx_w] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_rr_scheduler.sv
// Shares one fixed-latency pipeline among NUM_REQ requesters with round-robin
// arbitration. Traffic is held off while the reset tree and pipeline warm up,
// each issued item is tagged with its requester id, and the pipeline's valid
// output is steered back to the owning requester as resp_valid.
//   clk, rst_n      : clock, async active-low reset
//   req_if          : requester bus (req, req_data in; gnt, resp_valid out)
//   drain           : stop granting, let in-flight items finish
//   ready           : scheduler is in RUN
//   drained         : in DRAIN with nothing in flight
//   pipe_valid_in   : item valid towards the pipeline
//   pipe_in         : item data towards the pipeline
//   pipe_valid_out  : valid from the pipeline
//   tag_err         : sticky, pipeline valid disagreed with the tag tracker
module pipeline_rr_scheduler
  import pipeline_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 5,
  parameter int RST_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_rr_scheduler_if.slave req_if,
  input  logic                   drain,
  output logic                   ready,
  output logic                   drained,
  output logic                   pipe_valid_in,
  output logic [WIDTH-1:0]       pipe_in,
  input  logic                   pipe_valid_out,
  output logic                   tag_err
);

  localparam int ID_W     = id_width(NUM_REQ);
  localparam int CNT_W    = $clog2(LATENCY + 2);
  localparam int WARM_CYC = RST_LATENCY + LATENCY;
  localparam int WARM_W   = $clog2(WARM_CYC + 1);

  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);

  state_t              state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     pipe_id;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  resp;
  logic                any_gnt;
  logic [LATENCY-1:0]  tag_valid;
  logic [ID_W-1:0]     tag_id [LATENCY];
  logic                tail_valid;
  logic [ID_W-1:0]     tail_id;
  logic [CNT_W-1:0]    count;

  // Requests only reach the arbiter in RUN; a drain request wins over any
  // request raised in the same cycle.
  assign arb_req = (state == RUN && !drain) ? req_if.req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign any_gnt    = |gnt;
  assign req_if.gnt = gnt;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

  // Tail of the tag shifter lines up with pipe_valid_out.
  assign tail_valid = tag_valid[LATENCY-1];
  assign tail_id    = tag_id[LATENCY-1];

  always_comb begin
    resp = '0;
    if (tail_valid) resp[tail_id] = 1'b1;
  end

  assign req_if.resp_valid = resp;

  assign ready   = (state == RUN);
  assign drained = (state == DRAIN) && (count == '0) && !pipe_valid_in;

  // WARMUP waits out reset-tree depth plus pipeline depth so that every
  // pipeline stage has been flushed before the first item is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      case (state)
        WARMUP: begin
          if (warm_cnt == WARM_LAST) state <= RUN;
          else                       warm_cnt <= warm_cnt + 1'b1;
        end
        RUN:     if (drain)  state <= DRAIN;
        DRAIN:   if (!drain) state <= RUN;
        default: state <= WARMUP;
      endcase
    end
  end

  // Issue register, round-robin pointer, in-flight count and tag check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_in <= 1'b0;
      pipe_in       <= '0;
      pipe_id       <= '0;
      ptr           <= '0;
      count         <= '0;
      tag_err       <= 1'b0;
    end else begin
      pipe_valid_in <= any_gnt;
      if (any_gnt) begin
        pipe_in <= req_if.req_data[gnt_id];
        pipe_id <= gnt_id;
        ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end
      case ({any_gnt, tail_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Pipeline valid regs may come out of reset late, so WARMUP ignores them.
      if (state != WARMUP && pipe_valid_out != tail_valid) tag_err <= 1'b1;
    end
  end

  // Tag shifter fed by the issue register, one stage per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_valid[0] <= pipe_valid_in;
      tag_id[0]    <= pipe_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_rr_scheduler.sv
// Directed testbench for pipeline_rr_scheduler with a behavioural pipeline
// model and an ordering scoreboard of (id, data) pairs.
module tb_pipeline_rr_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int WIDTH       = 8;
  localparam int LATENCY     = 5;
  localparam int RST_LATENCY = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             drain;
  logic             ready;
  logic             drained;
  logic             pipe_valid_in;
  logic [WIDTH-1:0] pipe_in;
  logic             pipe_valid_out;
  logic             tag_err;
  logic             inject;

  int checks = 0;
  int errors = 0;

  pipeline_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  pipeline_rr_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .WIDTH       (WIDTH),
    .LATENCY     (LATENCY),
    .RST_LATENCY (RST_LATENCY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_if         (bus),
    .drain          (drain),
    .ready          (ready),
    .drained        (drained),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_in        (pipe_in),
    .pipe_valid_out (pipe_valid_out),
    .tag_err        (tag_err)
  );

  always #5 clk = ~clk;

  // Behavioural fixed-latency pipeline; inject forces a spurious valid.
  logic [LATENCY-1:0] pv_sr;
  logic [WIDTH-1:0]   pd_sr [LATENCY];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_sr <= '0;
      for (int i = 0; i < LATENCY; i++) pd_sr[i] <= '0;
    end else begin
      pv_sr[0] <= pipe_valid_in;
      pd_sr[0] <= pipe_in;
      for (int i = 1; i < LATENCY; i++) begin
        pv_sr[i] <= pv_sr[i-1];
        pd_sr[i] <= pd_sr[i-1];
      end
    end
  end

  assign pipe_valid_out = pv_sr[LATENCY-1] | inject;

  // Scoreboard: grants push (id, data), responses pop in order.
  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } item_t;

  item_t              sb_q[$];
  item_t              sb_item;
  logic [NUM_REQ-1:0] sb_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      checks++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("[TB] FAIL gnt_onehot0: gnt=%b", bus.gnt);
      end
      if (bus.gnt != '0) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL gnt_without_ready: gnt=%b ready=%b required ready=1", bus.gnt, ready);
        end
      end
      if (bus.resp_valid != '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL resp_unexpected: resp_valid=%b required 0000", bus.resp_valid);
        end else begin
          sb_item = sb_q.pop_front();
          sb_exp  = '0;
          sb_exp[sb_item.id] = 1'b1;
          if (bus.resp_valid !== sb_exp || pd_sr[LATENCY-1] !== sb_item.data) begin
            errors++;
            $display("[TB] FAIL resp_order: resp_valid=%b data=%h required %b data=%h",
                     bus.resp_valid, pd_sr[LATENCY-1], sb_exp, sb_item.data);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.gnt[i]) sb_q.push_back('{i, bus.req_data[i]});
      end
      checks++;
      if (sb_q.size() > LATENCY + 1) begin
        errors++;
        $display("[TB] FAIL inflight_bound: in flight %0d required <= %0d", sb_q.size(), LATENCY + 1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [NUM_REQ-1:0] r, input int k);
    bus.req = r;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i] = WIDTH'((k * 37 + i * 11 + 5) & 255);
  endtask

  // Reset and wait (bounded) until the scheduler reaches RUN with no requests.
  task automatic restart();
    bit seen;
    int n;
    rst_n  = 1'b0;
    drain  = 1'b0;
    inject = 1'b0;
    set_req('0, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    seen  = 1'b0;
    n     = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = ready;
      n++;
      next_cycle();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL restart_timeout: ready=%b after %0d cycles required 1", ready, n);
    end
  endtask

  task automatic test_reset();
    logic exp_ready;
    logic [NUM_REQ-1:0] exp_gnt;
    rst_n  = 1'b0;
    drain  = 1'b0;
    inject = 1'b0;
    set_req(4'b1111, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.resp_valid, ready, drained, pipe_valid_in, tag_err, pipe_in} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: gnt=%b resp=%b ready=%b drained=%b pvi=%b tag_err=%b pipe_in=%h required all 0",
                 bus.gnt, bus.resp_valid, ready, drained, pipe_valid_in, tag_err, pipe_in);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_ready = (c == 10);
      exp_gnt   = (c == 10) ? 4'b0001 : 4'b0000;
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL warmup_ready c%0d: ready=%b required %b", c, ready, exp_ready);
      end
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL warmup_gnt c%0d: gnt=%b required %b", c, bus.gnt, exp_gnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_resp;
    restart();
    for (int k = 0; k < 15; k++) begin
      set_req((k < 8) ? 4'b1111 : 4'b0000, k);
      @(negedge clk);
      exp_gnt  = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      exp_resp = (k >= 6 && k < 14) ? (4'b0001 << ((k - 6) % 4)) : 4'b0000;
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL rr_gnt k%0d: gnt=%b required %b", k, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.resp_valid !== exp_resp) begin
        errors++;
        $display("[TB] FAIL rr_resp k%0d: resp_valid=%b required %b", k, bus.resp_valid, exp_resp);
      end
      next_cycle();
    end
  endtask

  task automatic test_masked_req();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_resp;
    for (int k = 0; k < 10; k++) begin
      set_req((k < 3) ? 4'b1010 : 4'b0000, k);
      @(negedge clk);
      case (k)
        0, 2:    exp_gnt = 4'b0010;
        1:       exp_gnt = 4'b1000;
        default: exp_gnt = 4'b0000;
      endcase
      case (k)
        6, 8:    exp_resp = 4'b0010;
        7:       exp_resp = 4'b1000;
        default: exp_resp = 4'b0000;
      endcase
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL masked_gnt k%0d: gnt=%b required %b", k, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.resp_valid !== exp_resp) begin
        errors++;
        $display("[TB] FAIL masked_resp k%0d: resp_valid=%b required %b", k, bus.resp_valid, exp_resp);
      end
      next_cycle();
    end
  endtask

  task automatic test_drain();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_resp;
    logic exp_ready;
    logic exp_drained;
    for (int k = 0; k < 20; k++) begin
      drain = (k >= 3 && k <= 10);
      set_req((k <= 3 || k == 11 || k == 12) ? 4'b1111 : 4'b0000, k);
      @(negedge clk);
      case (k)
        0:       exp_gnt = 4'b0100;
        1:       exp_gnt = 4'b1000;
        2:       exp_gnt = 4'b0001;
        12:      exp_gnt = 4'b0010;
        default: exp_gnt = 4'b0000;
      endcase
      case (k)
        6:       exp_resp = 4'b0100;
        7:       exp_resp = 4'b1000;
        8:       exp_resp = 4'b0001;
        18:      exp_resp = 4'b0010;
        default: exp_resp = 4'b0000;
      endcase
      exp_ready   = (k <= 3) || (k >= 12);
      exp_drained = (k >= 9 && k <= 11);
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL drain_gnt k%0d: gnt=%b required %b", k, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.resp_valid !== exp_resp) begin
        errors++;
        $display("[TB] FAIL drain_resp k%0d: resp_valid=%b required %b", k, bus.resp_valid, exp_resp);
      end
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL drain_ready k%0d: ready=%b required %b", k, ready, exp_ready);
      end
      checks++;
      if (drained !== exp_drained) begin
        errors++;
        $display("[TB] FAIL drained k%0d: drained=%b required %b", k, drained, exp_drained);
      end
      next_cycle();
    end
    drain = 1'b0;
  endtask

  task automatic test_tag_err();
    logic exp_err;
    for (int k = 0; k < 6; k++) begin
      inject = (k == 0);
      set_req('0, k);
      if (k == 5) rst_n = 1'b0;
      @(negedge clk);
      exp_err = (k >= 1 && k <= 4);
      checks++;
      if (tag_err !== exp_err) begin
        errors++;
        $display("[TB] FAIL tag_err k%0d: tag_err=%b required %b", k, tag_err, exp_err);
      end
      next_cycle();
    end
    inject = 1'b0;
    restart();
  endtask

  task automatic test_reset_in_flight();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_resp;
    logic exp_ready;
    for (int k = 0; k < 22; k++) begin
      if (k == 4) rst_n = 1'b0;
      if (k == 5) rst_n = 1'b1;
      set_req((k <= 14) ? 4'b1111 : 4'b0000, k);
      @(negedge clk);
      if (k < 4)        exp_gnt = 4'b0001 << k;
      else if (k == 14) exp_gnt = 4'b0001;
      else              exp_gnt = 4'b0000;
      exp_resp  = (k == 20) ? 4'b0001 : 4'b0000;
      exp_ready = (k < 4) || (k >= 14);
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL rst_gnt k%0d: gnt=%b required %b", k, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.resp_valid !== exp_resp) begin
        errors++;
        $display("[TB] FAIL rst_resp k%0d: resp_valid=%b required %b", k, bus.resp_valid, exp_resp);
      end
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL rst_ready k%0d: ready=%b required %b", k, ready, exp_ready);
      end
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    drain  = 1'b0;
    inject = 1'b0;
    set_req('0, 0);
    next_cycle();
    test_reset();
    test_round_robin();
    test_masked_req();
    test_drain();
    test_tag_err();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
